// File: rtl/mmio_uart_tx_if.sv
// CPU data-port bus shared with the BRAM: byte enables, address, write data
// and one-cycle-latency read data.
interface mmio_uart_tx_if;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] di;
  logic [31:0] dout;

  modport master (output we, addr, di, input dout);
  modport slave  (input we, addr, di, output dout);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the BRAM
// port-B bus with identical one-cycle read latency.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nx;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_tx_en, r_irq_en, r_tx;
  logic [15:0]   r_div, r_cur_div, r_baud_cnt;
  logic [7:0]    r_shift, w_shift_nx;
  logic [2:0]    r_bit_idx, w_bit_idx_nx;
  logic [31:0]   r_do, w_rdata;
  logic [1:0]    w_reg;
  logic [15:0]   w_eff_div;
  logic          w_hit, w_wr, w_push, w_push_ok, w_pop, w_full, w_empty;
  logic          w_busy, w_period_end, w_tx_nx, w_unused;

  assign w_hit        = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_reg        = bus.addr[3:2];
  assign w_wr         = w_hit && (bus.we != 4'b0000);
  assign w_push       = w_wr && (w_reg == 2'd0) && bus.we[0];
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_busy       = (r_state != S_IDLE);
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_eff_div    = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_period_end = (r_baud_cnt == (r_cur_div - 16'd1));
  assign w_unused     = ^{bus.addr[1:0], bus.di[31:16]};

  // Frame sequencing; tx is registered from the next state and next shift value
  always_comb begin
    w_state_nx   = r_state;
    w_shift_nx   = r_shift;
    w_bit_idx_nx = r_bit_idx;
    w_pop        = 1'b0;
    w_tx_nx      = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_tx_en && !w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_fifo[r_rptr];
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_period_end) begin
          w_state_nx   = S_DATA;
          w_bit_idx_nx = 3'd0;
        end
      end
      S_DATA: begin
        if (w_period_end) begin
          w_shift_nx   = {1'b0, r_shift[7:1]};
          w_bit_idx_nx = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_period_end) begin
          if (r_tx_en && !w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_fifo[r_rptr];
            w_state_nx = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shift_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

  // Divisor is latched only at the start of each bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'd0;
      r_bit_idx  <= 3'd0;
      r_tx       <= 1'b1;
      r_baud_cnt <= 16'd0;
      r_cur_div  <= DEFAULT_DIV;
    end else begin
      r_state   <= w_state_nx;
      r_shift   <= w_shift_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_tx      <= w_tx_nx;
      if (w_pop || (w_busy && w_period_end)) begin
        r_baud_cnt <= 16'd0;
        r_cur_div  <= w_eff_div;
      end else if (w_busy) begin
        r_baud_cnt <= r_baud_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wptr] <= bus.di[7:0];
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      2'd1:    w_rdata = (32'(r_count) << 8) | {28'd0, r_ovf, w_empty, w_full, w_busy};
      2'd2:    w_rdata = 32'(r_div);
      2'd3:    w_rdata = {30'd0, r_irq_en, r_tx_en};
      default: w_rdata = 32'd0;
    endcase
  end

  // FIFO pointers, control registers and registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_div    <= DEFAULT_DIV;
      r_tx_en  <= 1'b0;
      r_irq_en <= 1'b0;
      r_do     <= 32'd0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_push && !w_push_ok)
        r_ovf <= 1'b1;
      else if (w_wr && (w_reg == 2'd1) && bus.we[0] && bus.di[3])
        r_ovf <= 1'b0;
      if (w_wr && (w_reg == 2'd2)) begin
        if (bus.we[0]) r_div[7:0]  <= bus.di[7:0];
        if (bus.we[1]) r_div[15:8] <= bus.di[15:8];
      end
      if (w_wr && (w_reg == 2'd3) && bus.we[0]) begin
        r_tx_en  <= bus.di[0];
        r_irq_en <= bus.di[1];
      end
      r_do <= w_hit ? w_rdata : 32'd0;
    end
  end

  assign bus.dout = r_do;
  assign tx       = r_tx;
  assign irq      = r_irq_en & w_empty & (r_state == S_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: expected tx levels are queued per clock
// when a frame is launched and compared on every falling edge.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam logic [31:0] A_TX    = BASE + 32'h0;
  localparam logic [31:0] A_STAT  = BASE + 32'h4;
  localparam logic [31:0] A_DIV   = BASE + 32'h8;
  localparam logic [31:0] A_CTRL  = BASE + 32'hC;

  logic clk, rst, tx, irq;
  logic exp_q [$];
  int n_checks, n_errors;
  logic [31:0] v;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; compare tx against the scoreboard head if one is due
  task automatic tick();
    logic e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tx", 32'(tx), 32'(e));
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input int div);
    for (int i = 0; i < div; i++) exp_q.push_back(1'b0);
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < div; k++) exp_q.push_back(b[j]);
    for (int m = 0; m < div; m++) exp_q.push_back(1'b1);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.addr = a;
    bus.di   = d;
    bus.we   = w;
    tick();
    bus.we   = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 4'b0000;
    tick();
    d = bus.dout;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    bus.we   = 4'b0000;
    bus.addr = 32'd0;
    bus.di   = 32'd0;
    tick();
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_do", bus.dout, 32'd0);
    rst = 1'b0;

    // Power-up register values
    bus_read(A_STAT, v);  check("por_status", v, 32'h0000_0004);
    bus_read(A_DIV, v);   check("por_div", v, 32'd868);
    bus_read(A_CTRL, v);  check("por_ctrl", v, 32'd0);
    bus_read(A_TX, v);    check("txdata_reads0", v, 32'd0);

    // Decode, byte lanes and read latency
    bus_write(A_DIV, 32'h0000_0004, 4'b0011);
    bus_read(A_DIV, v);               check("div_read", v, 32'd4);
    bus_read(BASE + 32'hA, v);        check("div_lowbits_ignored", v, 32'd4);
    bus_read(BASE + 32'h10, v);       check("miss_reads0", v, 32'd0);
    bus_write(A_DIV, 32'hABCD_0300, 4'b0010);
    bus_read(A_DIV, v);               check("div_lane1", v, 32'h0000_0304);
    bus_write(A_DIV, 32'h0000_0004, 4'b0011);
    bus_write(A_TX, 32'h0000_5A5A, 4'b0010);
    bus_read(A_STAT, v);              check("no_push_we1", v, 32'h0000_0004);
    bus_write(BASE + 32'h1C, 32'd1, 4'b0001);
    bus_read(A_CTRL, v);              check("miss_write", v, 32'd0);
    bus_write(A_CTRL, 32'd3, 4'b0010);
    bus_read(A_CTRL, v);              check("ctrl_we0_only", v, 32'd0);

    // Single frame 0xA5 at four clocks per bit
    bus_write(A_CTRL, 32'd1, 4'b0001);
    bus_write(A_TX, 32'h0000_00A5, 4'b0001);
    check("pre_start_idle", 32'(tx), 32'd1);
    push_frame(8'hA5, 4);
    push_idle(2);
    tick();
    for (int i = 1; i < 40; i++) begin
      bus_read(A_STAT, v);
      check("busy", 32'(v[0]), 32'd1);
    end
    tick();
    tick();
    bus_read(A_STAT, v);              check("single_done", v, 32'h0000_0004);

    // Three frames back to back at two clocks per bit
    bus_write(A_DIV, 32'd2, 4'b0011);
    bus_write(A_CTRL, 32'd0, 4'b0001);
    bus_write(A_TX, 32'h55, 4'b0001);
    bus_write(A_TX, 32'h00, 4'b0001);
    bus_write(A_TX, 32'hFF, 4'b0001);
    bus_read(A_STAT, v);              check("b2b_count3", v, 32'h0000_0300);
    bus_write(A_CTRL, 32'd1, 4'b0001);
    push_frame(8'h55, 2);
    push_frame(8'h00, 2);
    push_frame(8'hFF, 2);
    push_idle(2);
    repeat (62) tick();
    bus_read(A_STAT, v);              check("b2b_done", v, 32'h0000_0004);

    // Overflow on the ninth push into an eight-entry FIFO
    bus_write(A_CTRL, 32'd0, 4'b0001);
    for (int i = 0; i < 9; i++) bus_write(A_TX, 32'(8'h10 + 8'(i)), 4'b0001);
    bus_read(A_STAT, v);              check("ovf_set", v, 32'h0000_080A);
    bus_write(A_STAT, 32'h8, 4'b0001);
    bus_read(A_STAT, v);              check("ovf_clear", v, 32'h0000_0802);

    // Asynchronous reset in the middle of a frame
    bus_write(A_DIV, 32'd4, 4'b0011);
    bus_write(A_CTRL, 32'd1, 4'b0001);
    push_frame(8'h10, 4);
    repeat (6) tick();
    check("tx_pre_rst", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_do", bus.dout, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    bus_read(A_STAT, v);              check("rst_status", v, 32'h0000_0004);
    bus_read(A_DIV, v);               check("rst_div", v, 32'd868);
    bus_read(A_CTRL, v);              check("rst_ctrl", v, 32'd0);

    // tx_en dropped mid-frame, then irq after the last stop bit
    bus_write(A_DIV, 32'd4, 4'b0011);
    bus_write(A_TX, 32'h3C, 4'b0001);
    bus_write(A_TX, 32'hC3, 4'b0001);
    bus_write(A_CTRL, 32'd3, 4'b0001);
    push_frame(8'h3C, 4);
    push_idle(3);
    repeat (8) tick();
    bus_write(A_CTRL, 32'd2, 4'b0001);
    repeat (34) tick();
    bus_read(A_STAT, v);              check("disable_count1", v, 32'h0000_0100);
    check("irq_not_empty", 32'(irq), 32'd0);
    bus_write(A_CTRL, 32'd3, 4'b0001);
    push_frame(8'hC3, 4);
    push_idle(2);
    repeat (20) tick();
    check("irq_mid_frame", 32'(irq), 32'd0);
    repeat (20) tick();
    check("irq_stop_bit", 32'(irq), 32'd0);
    tick();
    check("irq_done", 32'(irq), 32'd1);
    tick();
    bus_read(A_STAT, v);              check("final_status", v, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that responds to the CPU's data-memory port and sits beside the BRAM on the same port-B bus: `we`, `addr`, `di`, `do`.
- Decodes a 16-byte register window and accepts byte stores into a TX FIFO.
- Serialises queued bytes as 8N1 frames on `tx`.
- Read data returns with one-cycle synchronous latency, identical to BRAM timing, so the LSU/WB path is unchanged.

Parameters:
- `BASE_ADDR`, 32'h0001_0000, base of the 16-byte register window; bits [3:0] must be 0.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..64.
- `DEFAULT_DIV`, 16'd868, reset value of `BAUDDIV` (clocks per bit).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  4  byte write enables (lane i = `di[8i+7:8i]`).
- `addr`  in  32  byte address from the CPU data port.
- `di`  in  32  write data.
- `do`  out  32  registered read data.
- `tx`  out  1  serial output, idle high.
- `irq`  out  1  TX-done interrupt, level.

Behaviour:
- **Decode.** `hit = (addr[31:4] == BASE_ADDR[31:4])`. Register = `addr[3:2]`; `addr[1:0]` is ignored.
- **Register map:**
  - 0x0 `TXDATA`: write-only; reads 0.
  - 0x4 `STATUS`: read-only except bit3.
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky, write 1 with `we[0]` to clear)
    - bits[14:8] FIFO count
  - 0x8 `BAUDDIV`: R/W, 16 bits; `we[0]` writes [7:0], `we[1]` writes [15:8]; upper bits read 0.
  - 0xC `CTRL`: R/W; bit0 tx_en, bit1 irq_en; `we[0]` only.
- **Read timing.** `do` is updated every rising edge from the current `addr`. `do = hit ? reg : 0`. Value is valid the cycle after `addr` is presented.
- **Write timing.** Writes take effect at the rising edge where `we != 0` and `hit`. Writes with `we == 0` or `!hit` have no effect.
- **TXDATA push.** A write to 0x0 with `we[0]=1` pushes `di[7:0]`.
  - If full and no pop this edge: byte dropped, overflow set.
  - Push and pop on the same edge: both succeed, count unchanged.
  - A write with `we[0]=0` pushes nothing.
- **FIFO.** Circular, read/write pointers wrap at `FIFO_DEPTH`. Count ranges 0..`FIFO_DEPTH`.
- **Baud counter.** Counts 0..eff_div-1, where eff_div = max(`BAUDDIV`, 1). Each bit period is eff_div clocks. A `BAUDDIV` change is sampled when a new bit period starts; the current bit is not stretched or cut.
- **FSM states and transitions:**
  - IDLE: `tx=1`. If tx_en and !empty, pop at this edge into the shift register, go to START, counter = 0.
  - START: `tx=0` for one bit period, then DATA with bit index 0.
  - DATA: `tx` = shift[0], LSB first. Shift right at the end of each period. After 8 bits, go to STOP.
  - STOP: `tx=1` for one bit period. At its end, if tx_en and !empty, pop and go directly to START (no idle gap); else go to IDLE.
- **Latency.** A `TXDATA` write at edge N with FIFO empty and FSM IDLE gives: pop at edge N+1, `tx` low from N+1 to N+1+eff_div. A full frame is 10×eff_div clocks.
- **tx_en cleared mid-frame.** The current frame completes; no further pops occur. FIFO contents are retained.
- **irq.** `irq = irq_en & empty & (state==IDLE)`, combinational from registered state.
- **Reset (async, any time including mid-frame):**
  - `tx=1`, `do=0`, `irq=0`, FSM IDLE.
  - FIFO cleared (count 0), overflow 0.
  - `BAUDDIV=DEFAULT_DIV`, `CTRL=0`.
  - Release takes effect at the first clock edge with `rst` low.

Test Plan:
- **Reset defaults.** Assert `rst` mid-frame at `BAUDDIV=4` → `tx` goes 1 immediately. After release, read 0x4 returns 32'h0000_0004; read 0x8 returns 868; `irq=0`.
- **Single frame.** `BAUDDIV=4`, `CTRL=1`, write 0x0 = 32'h0000_00A5 → `tx` low 4 clocks starting 1 cycle after the write, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high. Total 40 clocks; busy=1 throughout.
- **Back-to-back.** Push 3 bytes (0x55, 0x00, 0xFF) with `BAUDDIV=2` → 60 contiguous clocks, no idle gap between stop and next start. Then `STATUS` empty=1, busy=0.
- **Overflow.** `CTRL=0`, push 9 bytes into `FIFO_DEPTH=8` → count=8, full=1, overflow=1. Write 0x4 = 0x8 → overflow=0, count still 8.
- **Read latency and decode.** Present `addr=BASE+0x8` for one cycle → `do=BAUDDIV` on the next cycle. `addr=BASE+0x10` → `do=0`. A write with `we=4'b0010` to `TXDATA` pushes nothing.
- **irq and disable.** `CTRL=3` while sending 2 bytes; clear tx_en during the first frame → first frame completes, count stays 1, `irq=0`. Set `CTRL=3` → second frame sent, `irq=1` after its stop bit.
